// File: rtl/chess_pkg.sv
// chess_pkg: square encoding, side colors and move-kind codes shared by the pawn move generator.
`default_nettype none
package chess_pkg;

  typedef struct packed {
    logic king;   // bit2
    logic color;  // bit1, black=1
    logic occ;    // bit0
  } square_t;

  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

  typedef enum logic [1:0] {
    KIND_PUSH    = 2'd0,
    KIND_DOUBLE  = 2'd1,
    KIND_CAPTURE = 2'd2,
    KIND_EP      = 2'd3
  } mv_kind_e;

endpackage
`default_nettype wire

// File: rtl/pawn_cand_eval.sv
// pawn_cand_eval: legality and target square of one pawn candidate move (combinational).
// En-passant candidates exist only when PAWN_EN_PASSANT_EN is defined.
`default_nettype none
module pawn_cand_eval
  import chess_pkg::*;
#(
  parameter int BOARD_N = 8,
  localparam int CW = $clog2(BOARD_N)
) (
  input  logic [2:0]                            cand,
  input  logic [CW-1:0]                         row,
  input  logic [CW-1:0]                         col,
  input  logic                                  color,
  input  square_t [BOARD_N-1:0][BOARD_N-1:0]    board,
  input  logic                                  ep_valid,
  input  logic [CW-1:0]                         ep_col,
  output logic                                  legal,
  output logic [CW-1:0]                         tgt_row,
  output logic [CW-1:0]                         tgt_col,
  output mv_kind_e                              kind,
  output logic                                  promo,
  output logic                                  check
);

  int            fr_i, f2_i;
  logic          fwd_on, f2_on, has_left, has_right, start_row;
  logic [CW-1:0] fr, f2, cl, cr, last_row;
  square_t       sq_fwd, sq_f2, sq_dl, sq_dr;
  logic          push_ok, dbl_ok, dl_ok, dr_ok, epl_ok, epr_ok;

  always_comb begin
    fr_i = (color == BLACK) ? int'(row) + 1 : int'(row) - 1;
    f2_i = (color == BLACK) ? int'(row) + 2 : int'(row) - 2;
  end

  // Off-board indices are computed but never qualify a move, so nothing wraps.
  assign fwd_on    = (fr_i >= 0) && (fr_i < BOARD_N);
  assign f2_on     = (f2_i >= 0) && (f2_i < BOARD_N);
  assign fr        = CW'(fr_i);
  assign f2        = CW'(f2_i);
  assign cl        = col - CW'(1);
  assign cr        = col + CW'(1);
  assign has_left  = (col != '0);
  assign has_right = (int'(col) < BOARD_N - 1);
  assign start_row = (color == BLACK) ? (int'(row) == 1) : (int'(row) == BOARD_N - 2);
  assign last_row  = (color == BLACK) ? CW'(BOARD_N - 1) : '0;

  assign sq_fwd = board[fr][col];
  assign sq_f2  = board[f2][col];
  assign sq_dl  = board[fr][cl];
  assign sq_dr  = board[fr][cr];

  assign push_ok = fwd_on && !sq_fwd.occ;
  assign dbl_ok  = start_row && push_ok && f2_on && !sq_f2.occ;
  assign dl_ok   = has_left  && fwd_on && sq_dl.occ && (sq_dl.color != color);
  assign dr_ok   = has_right && fwd_on && sq_dr.occ && (sq_dr.color != color);

`ifdef PAWN_EN_PASSANT_EN
  square_t sq_al, sq_ar;
  logic    ep_row_ok;
  assign sq_al     = board[row][cl];
  assign sq_ar     = board[row][cr];
  assign ep_row_ok = (int'(row) == ((color == BLACK) ? BOARD_N - 4 : 3));
  assign epl_ok = ep_valid && has_left && (ep_col == cl) && ep_row_ok && fwd_on &&
                  !sq_dl.occ && sq_al.occ && (sq_al.color != color);
  assign epr_ok = ep_valid && has_right && (ep_col == cr) && ep_row_ok && fwd_on &&
                  !sq_dr.occ && sq_ar.occ && (sq_ar.color != color);
`else
  logic unused_ep;
  assign unused_ep = ^{ep_valid, ep_col};
  assign epl_ok    = 1'b0;
  assign epr_ok    = 1'b0;
`endif

  always_comb begin
    legal   = 1'b0;
    tgt_row = fr;
    tgt_col = col;
    kind    = KIND_PUSH;
    check   = 1'b0;
    case (cand)
      3'd0: legal = push_ok;
      3'd1: begin legal = dbl_ok; tgt_row = f2; kind = KIND_DOUBLE; end
      3'd2: begin legal = dl_ok; tgt_col = cl; kind = KIND_CAPTURE; check = sq_dl.king; end
      3'd3: begin legal = dr_ok; tgt_col = cr; kind = KIND_CAPTURE; check = sq_dr.king; end
      3'd4: begin legal = epl_ok; tgt_col = cl; kind = KIND_EP; end
      3'd5: begin legal = epr_ok; tgt_col = cr; kind = KIND_EP; end
      default: legal = 1'b0;
    endcase
    promo = (tgt_row == last_row);
  end

endmodule
`default_nettype wire

// File: rtl/pawn_move_gen.sv
// pawn_move_gen: streams the legal moves of one pawn, one candidate per SCAN cycle.
// Define PAWN_EN_PASSANT_EN to add the two en-passant candidates.
`default_nettype none
module pawn_move_gen
  import chess_pkg::*;
#(
  parameter int BOARD_N = 8,
  localparam int CW = $clog2(BOARD_N)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic [CW-1:0]                         req_row,
  input  logic [CW-1:0]                         req_col,
  input  logic                                  req_color,
  input  square_t [BOARD_N-1:0][BOARD_N-1:0]    board,
  input  logic                                  ep_valid,
  input  logic [CW-1:0]                         ep_col,
  output logic                                  mv_valid,
  input  logic                                  mv_ready,
  output logic [CW-1:0]                         mv_row,
  output logic [CW-1:0]                         mv_col,
  output logic [1:0]                            mv_kind,
  output logic                                  mv_promo,
  output logic                                  mv_check,
  output logic                                  done,
  output logic [2:0]                            done_count
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EMIT, S_DONE} state_e;

`ifdef PAWN_EN_PASSANT_EN
  localparam logic [2:0] CAND_LAST = 3'd5;
`else
  localparam logic [2:0] CAND_LAST = 3'd3;
`endif

  state_e                             state;
  logic [2:0]                         cand, count;
  logic [CW-1:0]                      lat_row, lat_col, lat_ep_col;
  logic                               lat_color, lat_ep_valid;
  square_t [BOARD_N-1:0][BOARD_N-1:0] lat_board;

  logic          ev_legal, ev_promo, ev_check;
  logic [CW-1:0] ev_row, ev_col;
  mv_kind_e      ev_kind;

  pawn_cand_eval #(.BOARD_N(BOARD_N)) u_eval (
    .cand     (cand),
    .row      (lat_row),
    .col      (lat_col),
    .color    (lat_color),
    .board    (lat_board),
    .ep_valid (lat_ep_valid),
    .ep_col   (lat_ep_col),
    .legal    (ev_legal),
    .tgt_row  (ev_row),
    .tgt_col  (ev_col),
    .kind     (ev_kind),
    .promo    (ev_promo),
    .check    (ev_check)
  );

  assign req_ready = (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cand       <= '0;
      count      <= '0;
      mv_valid   <= 1'b0;
      mv_row     <= '0;
      mv_col     <= '0;
      mv_kind    <= '0;
      mv_promo   <= 1'b0;
      mv_check   <= 1'b0;
      done       <= 1'b0;
      done_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (req_valid) begin
          lat_row      <= req_row;
          lat_col      <= req_col;
          lat_color    <= req_color;
          lat_board    <= board;
          lat_ep_valid <= ep_valid;
          lat_ep_col   <= ep_col;
          cand         <= '0;
          count        <= '0;
          state        <= S_SCAN;
        end
        S_SCAN: begin
          if (ev_legal) begin
            mv_valid <= 1'b1;
            mv_row   <= ev_row;
            mv_col   <= ev_col;
            mv_kind  <= ev_kind;
            mv_promo <= ev_promo;
            mv_check <= ev_check;
            state    <= S_EMIT;
          end else if (cand == CAND_LAST) begin
            done       <= 1'b1;
            done_count <= count;
            state      <= S_DONE;
          end else begin
            cand <= cand + 3'd1;
          end
        end
        S_EMIT: if (mv_ready) begin
          mv_valid <= 1'b0;
          count    <= count + 3'd1;
          // Emitting the final candidate goes straight to DONE; there is nothing left to scan.
          if (cand == CAND_LAST) begin
            done       <= 1'b1;
            done_count <= count + 3'd1;
            state      <= S_DONE;
          end else begin
            cand  <= cand + 3'd1;
            state <= S_SCAN;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pawn_move_gen.sv
// tb_pawn_move_gen: directed pawn queries with hand-computed move lists and timing.
`default_nettype none
module tb_pawn_move_gen;
  import chess_pkg::*;

  localparam int N = 8;
`ifdef PAWN_EN_PASSANT_EN
  localparam int NC = 6;
`else
  localparam int NC = 4;
`endif

  logic clk = 1'b0;
  logic reset, req_valid, req_ready, req_color, ep_valid, mv_valid, mv_ready;
  logic mv_promo, mv_check, done;
  logic [2:0] req_row, req_col, ep_col, mv_row, mv_col, done_count;
  logic [1:0] mv_kind;
  square_t [N-1:0][N-1:0] brd;

  int checks = 0;
  int failures = 0;

  int         n_mv, dcyc;
  logic [2:0] dcnt;
  logic [2:0] m_row [8];
  logic [2:0] m_col [8];
  logic [1:0] m_kind [8];
  logic       m_promo [8];
  logic       m_check [8];

  pawn_move_gen #(.BOARD_N(N)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_row(req_row), .req_col(req_col), .req_color(req_color), .board(brd),
    .ep_valid(ep_valid), .ep_col(ep_col), .mv_valid(mv_valid), .mv_ready(mv_ready),
    .mv_row(mv_row), .mv_col(mv_col), .mv_kind(mv_kind), .mv_promo(mv_promo),
    .mv_check(mv_check), .done(done), .done_count(done_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_board();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        brd[r][c] = '0;
  endtask

  task automatic put(input int r, input int c, input logic color, input logic king);
    brd[r][c] = {king, color, 1'b1};
  endtask

  task automatic start_query(input int r, input int c, input logic color);
    chk("req_ready_idle", req_ready, 1);
    req_row   = 3'(r);
    req_col   = 3'(c);
    req_color = color;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("req_ready_busy", req_ready, 0);
  endtask

  task automatic run_collect();
    n_mv = 0;
    dcyc = -1;
    dcnt = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (mv_valid && n_mv < 8) begin
        m_row[n_mv]   = mv_row;
        m_col[n_mv]   = mv_col;
        m_kind[n_mv]  = mv_kind;
        m_promo[n_mv] = mv_promo;
        m_check[n_mv] = mv_check;
        n_mv++;
      end
      if (done) begin
        dcyc = k;
        dcnt = done_count;
        break;
      end
    end
    if (dcyc < 0) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
    chk("done_pulse_width", done, 0);
  endtask

  task automatic check_move(input string tag, input int i, input int r, input int c,
                            input int kind, input logic promo, input logic check);
    if (i < n_mv) begin
      chk({tag, "_row"},   m_row[i],   r);
      chk({tag, "_col"},   m_col[i],   c);
      chk({tag, "_kind"},  m_kind[i],  kind);
      chk({tag, "_promo"}, m_promo[i], promo);
      chk({tag, "_check"}, m_check[i], check);
    end else begin
      chk({tag, "_missing"}, n_mv, i + 1);
    end
  endtask

  task automatic check_end(input string tag, input int nmv, input int cnt, input int cyc);
    chk({tag, "_nmoves"},     n_mv, nmv);
    chk({tag, "_done_count"}, dcnt, cnt);
    chk({tag, "_latency"},    dcyc, cyc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_row = '0; req_col = '0; req_color = WHITE;
    ep_valid = 1'b0; ep_col = '0; mv_ready = 1'b1;
    clear_board();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_mv_valid", mv_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_done_count", done_count, 0);
    chk("rst_mv_fields", {mv_row, mv_col, mv_kind, mv_promo, mv_check}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // White start-row pawn, empty board; board changes after acceptance are ignored.
    clear_board();
    start_query(6, 4, WHITE);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        brd[r][c] = {1'b0, BLACK, 1'b1};
    run_collect();
    check_move("w_push", 0, 5, 4, 0, 0, 0);
    check_move("w_dbl", 1, 4, 4, 1, 0, 0);
    check_end("w_start", 2, 2, NC + 2);

    // Black on column 0 with a white king diagonally right.
    clear_board();
    put(2, 1, WHITE, 1'b1);
    start_query(1, 0, BLACK);
    run_collect();
    check_move("b_push", 0, 2, 0, 0, 0, 0);
    check_move("b_dbl", 1, 3, 0, 1, 0, 0);
    check_move("b_capk", 2, 2, 1, 2, 0, 1);
    check_end("b_edge", 3, 3, NC + 3);

    // Promotion push and promotion capture.
    clear_board();
    put(0, 2, BLACK, 1'b0);
    start_query(1, 3, WHITE);
    run_collect();
    check_move("p_push", 0, 0, 3, 0, 1, 0);
    check_move("p_cap", 1, 0, 2, 2, 1, 0);
    check_end("promo", 2, 2, NC + 2);

    // Own-color piece is not capturable; opposing one is.
    clear_board();
    put(5, 3, WHITE, 1'b0);
    put(5, 5, BLACK, 1'b0);
    start_query(6, 4, WHITE);
    run_collect();
    check_move("o_cap", 2, 5, 5, 2, 0, 0);
    check_end("own", 3, 3, NC + 3);

    // Blocked push also blocks the double step.
    clear_board();
    put(4, 4, BLACK, 1'b0);
    start_query(6, 4, WHITE);
    run_collect();
    check_move("blk_push", 0, 5, 4, 0, 0, 0);
    check_end("blk2", 1, 1, NC + 1);
    clear_board();
    put(5, 4, BLACK, 1'b0);
    start_query(6, 4, WHITE);
    run_collect();
    check_end("blk1", 0, 0, NC);

    // Last rank, right edge: nothing at all.
    clear_board();
    put(1, 6, BLACK, 1'b0);
    start_query(0, 7, WHITE);
    run_collect();
    check_end("corner", 0, 0, NC);

    // En passant to the right with the forward square blocked.
    clear_board();
    put(3, 5, BLACK, 1'b0);
    put(2, 4, WHITE, 1'b0);
    ep_valid = 1'b1;
    ep_col = 3'd5;
    start_query(3, 4, WHITE);
    ep_valid = 1'b0;
    run_collect();
`ifdef PAWN_EN_PASSANT_EN
    check_move("ep", 0, 2, 5, 3, 0, 0);
    check_end("ep", 1, 1, NC + 1);
`else
    check_end("ep_off", 0, 0, NC);
`endif

    // Back-pressure on the first move: outputs held, nothing skipped.
    clear_board();
    mv_ready = 1'b0;
    start_query(6, 4, WHITE);
    begin
      int w = 0;
      while (!mv_valid && w < 20) begin @(posedge clk); #1; w++; end
    end
    chk("hold_seen", mv_valid, 1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("hold_valid", mv_valid, 1);
      chk("hold_move", {mv_row, mv_col, mv_kind}, {3'd5, 3'd4, 2'd0});
      chk("hold_req_ready", req_ready, 0);
    end
    mv_ready = 1'b1;
    run_collect();
    check_move("hold_dbl", 0, 4, 4, 1, 0, 0);
    chk("hold_done_count", dcnt, 2);
    chk("hold_done_seen", dcyc > 0, 1);

    // Reset while a move is pending in EMIT.
    clear_board();
    mv_ready = 1'b0;
    start_query(6, 4, WHITE);
    begin
      int w = 0;
      while (!mv_valid && w < 20) begin @(posedge clk); #1; w++; end
    end
    chk("rst_emit_seen", mv_valid, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_emit_valid", mv_valid, 0);
    chk("rst_emit_ready", req_ready, 1);
    chk("rst_emit_done_count", done_count, 0);
    chk("rst_emit_fields", {mv_row, mv_col, mv_kind, mv_promo, mv_check}, 0);
    reset = 1'b0;
    mv_ready = 1'b1;
    begin
      int seen = 0;
      repeat (10) begin
        @(posedge clk); #1;
        if (done || mv_valid) seen++;
      end
      chk("rst_emit_no_done", seen, 0);
    end

    // Recovery after the abort.
    start_query(6, 4, WHITE);
    run_collect();
    check_end("recover", 2, 2, NC + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
